// File: rtl/tmds_rx_decoder_if.sv
// rtl/tmds_rx_decoder_if.sv - serial bit stream in, decoded TMDS word stream out (stats ports with TMDS_RX_STATS_EN)
interface tmds_rx_decoder_if;
    logic        bit_en;
    logic        serial_in;
    logic        word_valid;
    logic [7:0]  data_out;
    logic [1:0]  ctrl_out;
    logic        de_out;
    logic        locked;
    logic        word_err;
`ifdef TMDS_RX_STATS_EN
    logic [15:0] err_count;
    logic        lock_loss;

    modport master (
        output bit_en, serial_in,
        input  word_valid, data_out, ctrl_out, de_out, locked, word_err,
        input  err_count, lock_loss
    );
    modport slave (
        input  bit_en, serial_in,
        output word_valid, data_out, ctrl_out, de_out, locked, word_err,
        output err_count, lock_loss
    );
`else
    modport master (
        output bit_en, serial_in,
        input  word_valid, data_out, ctrl_out, de_out, locked, word_err
    );
    modport slave (
        input  bit_en, serial_in,
        output word_valid, data_out, ctrl_out, de_out, locked, word_err
    );
`endif
endinterface

// File: rtl/tmds_rx_decoder.sv
// rtl/tmds_rx_decoder.sv - TMDS channel deserializer, token alignment and 10b->8b decode (optional TMDS_RX_STATS_EN)
module tmds_rx_decoder #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 8
) (
    input logic             clk,
    input logic             rst,
    tmds_rx_decoder_if.slave bus
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [9:0]  shreg;
    logic [9:0]  win;
    logic [3:0]  bit_cnt;
    logic [3:0]  tok_cnt, tok_nxt;
    logic [7:0]  err_cnt, err_nxt;
    logic        pend;
    logic        win_tok;
    logic        sr_tok;
    logic [1:0]  sr_code;
    logic [7:0]  dprime;
    logic [7:0]  dec_data;
    logic [3:0]  n_trans;
    logic        sr_illegal;

    function automatic logic is_token(input logic [9:0] w);
        return (w == 10'b1101010100) || (w == 10'b0010101011) ||
               (w == 10'b0101010100) || (w == 10'b1010101011);
    endfunction

    // Window as it will look after the current bit step shifts in serial_in
    assign win     = {bus.serial_in, shreg[9:1]};
    assign win_tok = is_token(win);
    assign sr_tok  = is_token(shreg);

    // Decode the completed word held in the shift register for emission
    always_comb begin
        sr_code = 2'b00;
        case (shreg)
            10'b0010101011: sr_code = 2'b01;
            10'b0101010100: sr_code = 2'b10;
            10'b1010101011: sr_code = 2'b11;
            default:        sr_code = 2'b00;
        endcase
        dprime      = shreg[9] ? ~shreg[7:0] : shreg[7:0];
        dec_data    = 8'd0;
        dec_data[0] = dprime[0];
        for (int i = 1; i < 8; i++)
            dec_data[i] = shreg[8] ? (dprime[i] ^ dprime[i-1]) : ~(dprime[i] ^ dprime[i-1]);
        n_trans = 4'd0;
        for (int i = 0; i < 9; i++)
            n_trans = n_trans + {3'b000, shreg[i] ^ shreg[i+1]};
        sr_illegal = !sr_tok && (n_trans >= 4'd7);
    end

    // Alignment FSM next state and token/error counter updates
    always_comb begin
        state_nxt = state;
        tok_nxt   = tok_cnt;
        err_nxt   = err_cnt;
        case (state)
            HUNT: begin
                if (bus.bit_en && win_tok) begin
                    tok_nxt   = 4'd1;
                    state_nxt = VERIFY;
                end
            end
            VERIFY: begin
                if (bus.bit_en && bit_cnt == 4'd9) begin
                    if (win_tok) begin
                        tok_nxt = tok_cnt + 4'd1;
                        if (tok_cnt + 4'd1 == 4'(LOCK_COUNT))
                            state_nxt = LOCKED;
                    end else begin
                        tok_nxt   = 4'd0;
                        state_nxt = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (pend) begin
                    if (sr_tok) begin
                        err_nxt = 8'd0;
                    end else if (sr_illegal) begin
                        if (err_cnt + 8'd1 == 8'(ERR_LIMIT)) begin
                            err_nxt   = 8'd0;
                            tok_nxt   = 4'd0;
                            state_nxt = HUNT;
                        end else begin
                            err_nxt = err_cnt + 8'd1;
                        end
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // State register, counters and shift window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= HUNT;
            shreg   <= 10'd0;
            bit_cnt <= 4'd0;
            tok_cnt <= 4'd0;
            err_cnt <= 8'd0;
            pend    <= 1'b0;
        end else begin
            state   <= state_nxt;
            tok_cnt <= tok_nxt;
            err_cnt <= err_nxt;
            pend    <= bus.bit_en && (state == LOCKED) && (bit_cnt == 4'd9);
            if (bus.bit_en) begin
                shreg <= win;
                if (state == HUNT && win_tok)
                    bit_cnt <= 4'd0;
                else
                    bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
            end
        end
    end

    // Registered outputs, updated one clk after the word-completing bit step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.word_valid <= 1'b0;
            bus.word_err   <= 1'b0;
            bus.data_out   <= 8'd0;
            bus.ctrl_out   <= 2'd0;
            bus.de_out     <= 1'b0;
            bus.locked     <= 1'b0;
        end else begin
            bus.locked     <= (state_nxt == LOCKED);
            bus.word_valid <= pend;
            bus.word_err   <= pend && sr_illegal;
            if (pend) begin
                bus.de_out <= !sr_tok;
                if (sr_tok)
                    bus.ctrl_out <= sr_code;
                else
                    bus.data_out <= dec_data;
            end
        end
    end

`ifdef TMDS_RX_STATS_EN
    // Saturating illegal-word count and a pulse on every loss of lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err_count <= 16'd0;
            bus.lock_loss <= 1'b0;
        end else begin
            bus.lock_loss <= (state == LOCKED) && (state_nxt == HUNT);
            if (pend && sr_illegal && bus.err_count != 16'hFFFF)
                bus.err_count <= bus.err_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_tmds_rx_decoder.sv
// tb/tb_tmds_rx_decoder.sv - table-driven bench for tmds_rx_decoder
module tb_tmds_rx_decoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tmds_rx_decoder_if bus();

    tmds_rx_decoder #(.LOCK_COUNT(4), .ERR_LIMIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] T3 = 10'b1010101011;

    typedef struct {
        logic [9:0] q;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       err;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de;
        logic       err;
        logic       lk;
        logic       ll;
        logic       en1;
        logic       en2;
    } cap_t;

    vec_t vecs[10];
    cap_t caps[$];
    cap_t mon_c;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ll_pulses = 0;
    logic en_d1 = 1'b0;
    logic en_d2 = 1'b0;

    always @(posedge clk) begin
        en_d1 <= bus.bit_en;
        en_d2 <= en_d1;
    end

    always @(negedge clk) begin
        if (!rst && bus.word_valid) begin
            mon_c.data = bus.data_out;
            mon_c.ctrl = bus.ctrl_out;
            mon_c.de   = bus.de_out;
            mon_c.err  = bus.word_err;
            mon_c.lk   = bus.locked;
            mon_c.en1  = en_d1;
            mon_c.en2  = en_d2;
`ifdef TMDS_RX_STATS_EN
            mon_c.ll   = bus.lock_loss;
`else
            mon_c.ll   = 1'b0;
`endif
            caps.push_back(mon_c);
        end
`ifdef TMDS_RX_STATS_EN
        if (!rst && bus.lock_loss) ll_pulses++;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        bus.bit_en = 1'b1;
        bus.serial_in = b;
        repeat (gap) begin
            @(negedge clk);
            bus.bit_en = 1'b0;
        end
    endtask

    task automatic send_word(input logic [9:0] w, input int gap);
        for (int i = 0; i < 10; i++) send_bit(w[i], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.bit_en = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.bit_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        caps.delete();
        ll_pulses = 0;
    endtask

    task automatic acquire_lock(input int gap, input string tag);
        send_word(10'd0, gap);
        for (int k = 0; k < 3; k++) send_word(T0, gap);
        idle(1);
        check({tag, "_locked_after_3"}, bus.locked, 1'b0);
        send_word(T0, gap);
        idle(1);
        check({tag, "_locked_after_4"}, bus.locked, 1'b1);
        check({tag, "_no_emit_before_lock"}, caps.size(), 0);
    endtask

    task automatic run_table(input int gap, input string tag);
        acquire_lock(gap, tag);
        for (int i = 0; i < 10; i++) send_word(vecs[i].q, gap);
        idle(4);
        check({tag, "_word_count"}, caps.size(), 10);
        for (int i = 0; i < 10 && i < caps.size(); i++) begin
            check($sformatf("%s_row%0d_de", tag, i), caps[i].de, vecs[i].de);
            check($sformatf("%s_row%0d_data", tag, i), caps[i].data, vecs[i].data);
            check($sformatf("%s_row%0d_ctrl", tag, i), caps[i].ctrl, vecs[i].ctrl);
            check($sformatf("%s_row%0d_err", tag, i), caps[i].err, vecs[i].err);
            check($sformatf("%s_row%0d_locked", tag, i), caps[i].lk, 1'b1);
            check($sformatf("%s_row%0d_step_before", tag, i), caps[i].en2, 1'b1);
            if (gap > 0)
                check($sformatf("%s_row%0d_idle_at_emit", tag, i), caps[i].en1, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{T0,            1'b0, 8'h00, 2'b00, 1'b0};
        vecs[1] = '{10'b1000000000, 1'b1, 8'hFF, 2'b00, 1'b0};
        vecs[2] = '{T1,            1'b0, 8'hFF, 2'b01, 1'b0};
        vecs[3] = '{10'b0100000000, 1'b1, 8'h00, 2'b01, 1'b0};
        vecs[4] = '{10'b0111111111, 1'b1, 8'h01, 2'b01, 1'b0};
        vecs[5] = '{T2,            1'b0, 8'h01, 2'b10, 1'b0};
        vecs[6] = '{10'b0011110000, 1'b1, 8'hEE, 2'b10, 1'b0};
        vecs[7] = '{T3,            1'b0, 8'hEE, 2'b11, 1'b0};
        vecs[8] = '{10'b0101010101, 1'b1, 8'hFF, 2'b11, 1'b1};
        vecs[9] = '{T0,            1'b0, 8'hFF, 2'b00, 1'b0};

        bus.bit_en = 1'b0;
        bus.serial_in = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_word_valid", bus.word_valid, 1'b0);
        check("rst_data_out", bus.data_out, 8'h00);
        check("rst_ctrl_out", bus.ctrl_out, 2'b00);
        check("rst_de_out", bus.de_out, 1'b0);
        check("rst_locked", bus.locked, 1'b0);
        check("rst_word_err", bus.word_err, 1'b0);
`ifdef TMDS_RX_STATS_EN
        check("rst_err_count", bus.err_count, 16'd0);
        check("rst_lock_loss", bus.lock_loss, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_table(0, "cont");

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_data_out", bus.data_out, 8'h00);
        check("midrst_locked", bus.locked, 1'b0);
        check("midrst_word_valid", bus.word_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        caps.delete();
        idle(5);
        check("midrst_locked_after_release", bus.locked, 1'b0);

        run_table(2, "thr");

        do_reset();
        send_word(10'd0, 0);
        send_word(T0, 0);
        send_word(T0, 0);
        send_word(10'b0100000000, 0);
        idle(1);
        check("verify_break_locked", bus.locked, 1'b0);
        for (int k = 0; k < 3; k++) send_word(T0, 0);
        idle(1);
        check("verify_rehunt_3tok_locked", bus.locked, 1'b0);
        send_word(T0, 0);
        idle(1);
        check("verify_rehunt_4tok_locked", bus.locked, 1'b1);
        check("verify_no_emit", caps.size(), 0);

        do_reset();
        acquire_lock(0, "loss");
        for (int k = 0; k < 8; k++) send_word(10'b1010101010, 0);
        idle(4);
        check("loss_word_count", caps.size(), 8);
        for (int k = 0; k < 8 && k < caps.size(); k++) begin
            check($sformatf("loss_w%0d_err", k), caps[k].err, 1'b1);
            check($sformatf("loss_w%0d_data", k), caps[k].data, 8'h01);
            check($sformatf("loss_w%0d_de", k), caps[k].de, 1'b1);
            check($sformatf("loss_w%0d_locked", k), caps[k].lk, (k < 7) ? 1'b1 : 1'b0);
        end
        check("loss_locked_final", bus.locked, 1'b0);
`ifdef TMDS_RX_STATS_EN
        check("loss_err_count", bus.err_count, 16'd8);
        check("loss_lock_loss_pulses", ll_pulses, 1);
        if (caps.size() == 8) check("loss_lock_loss_on_8th", caps[7].ll, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
